cla: RTL and testbench

- 32-bit two-level carry-lookahead adder with registered outputs.
- Computes S = A + B + Cin and the carry-out Cout.
- Serves as the datapath adder for ALU and address-generation blocks.
- Single clock domain; one cycle of latency from input sample to registered result.

---
 rtl/cla.sv | 152 +++++++++++++++
 tb/tb_cla.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cla.sv
// 32-bit two-level carry-lookahead adder with a registered sum, carry-out and valid.
// Define CLA_OVF_EN to add the registered signed-overflow output ovf.
module cla #(
  parameter int WIDTH = 32,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
`ifdef CLA_OVF_EN
  output logic             ovf,
`endif
  output logic             out_valid
);

  localparam int NG  = WIDTH / GROUP;  // first-level groups
  localparam int GPS = 16 / GROUP;     // groups per 16-bit super-group
  localparam int NSG = WIDTH / 16;     // super-groups

  // Carries into each of four positions, every one a flat SOP of ci and (g,p).
  function automatic logic [3:0] lookahead4(input logic [3:0] gi, input logic [3:0] pi,
                                            input logic ci);
    logic [3:0] cv;
    logic       acc;
    logic       term;
    cv    = '0;
    cv[0] = ci;
    for (int k = 1; k < 4; k++) begin
      acc = ci;
      for (int j = 0; j < k; j++) acc = acc & pi[j];
      for (int j = 0; j < k; j++) begin
        term = gi[j];
        for (int m = j + 1; m < k; m++) term = term & pi[m];
        acc = acc | term;
      end
      cv[k] = acc;
    end
    return cv;
  endfunction

  // Block generate/propagate {G,P} of four (g,p) pairs.
  function automatic logic [1:0] gp4(input logic [3:0] gi, input logic [3:0] pi);
    logic gg;
    logic term;
    gg = 1'b0;
    for (int j = 0; j < 4; j++) begin
      term = gi[j];
      for (int m = j + 1; m < 4; m++) term = term & pi[m];
      gg = gg | term;
    end
    return {gg, &pi};
  endfunction

  logic [WIDTH-1:0] g, p, sum;
  logic [WIDTH:0]   c;
  logic [NG-1:0]    grp_g, grp_p, gc;
  logic [NSG-1:0]   sg_g, sg_p;
  logic [NSG:0]     sc;
  logic             sc_acc, sc_term;

  always_comb begin
    g       = A & B;
    p       = A ^ B;
    grp_g   = '0;
    grp_p   = '0;
    sg_g    = '0;
    sg_p    = '0;
    sc      = '0;
    gc      = '0;
    c       = '0;
    sc_acc  = 1'b0;
    sc_term = 1'b0;

    for (int k = 0; k < NG; k++)
      {grp_g[k], grp_p[k]} = gp4(g[GROUP*k +: 4], p[GROUP*k +: 4]);
    for (int s = 0; s < NSG; s++)
      {sg_g[s], sg_p[s]} = gp4(grp_g[GPS*s +: 4], grp_p[GPS*s +: 4]);

    // Super-group carry-ins are flattened from Cin so no carry ripples between halves.
    sc[0] = Cin;
    for (int s = 1; s <= NSG; s++) begin
      sc_acc = Cin;
      for (int j = 0; j < s; j++) sc_acc = sc_acc & sg_p[j];
      for (int j = 0; j < s; j++) begin
        sc_term = sg_g[j];
        for (int m = j + 1; m < s; m++) sc_term = sc_term & sg_p[m];
        sc_acc = sc_acc | sc_term;
      end
      sc[s] = sc_acc;
    end

    for (int s = 0; s < NSG; s++)
      gc[GPS*s +: 4] = lookahead4(grp_g[GPS*s +: 4], grp_p[GPS*s +: 4], sc[s]);
    for (int k = 0; k < NG; k++)
      c[GROUP*k +: 4] = lookahead4(g[GROUP*k +: 4], p[GROUP*k +: 4], gc[k]);
    c[WIDTH] = sc[NSG];
    sum      = p ^ c[WIDTH-1:0];
  end

  // Output register stage
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             out_valid_q, out_valid_d;

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign S         = s_q;
  assign Cout      = cout_q;
  assign out_valid = out_valid_q;

`ifdef CLA_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if (in_valid) ovf_d = c[WIDTH] ^ c[WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla.sv
// Testbench for cla: directed vector table, back-to-back/hold/reset sequences,
// and randomized traffic against an arithmetic reference model.
module tb_cla;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] A, B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic        out_valid;
`ifdef CLA_OVF_EN
  logic        ovf;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  cla #(.WIDTH(32), .GROUP(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .S        (S),
    .Cout     (Cout),
`ifdef CLA_OVF_EN
    .ovf      (ovf),
`endif
    .out_valid(out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit addition and sign-rule overflow.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic cin);
    logic [32:0] full;
    logic        v;
    full = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    v    = (a[31] == b[31]) && (full[31] != a[31]);
    return {v, full};
  endfunction

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci);
    in_valid = v;
    A        = a;
    B        = b;
    Cin      = ci;
  endtask

  task automatic check_out(input string tag, input logic [31:0] es, input logic ec,
                           input logic ev, input logic eo);
    check({tag, ".S"}, {32'd0, S}, {32'd0, es});
    check({tag, ".Cout"}, {63'd0, Cout}, {63'd0, ec});
    check({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, ev});
`ifdef CLA_OVF_EN
    check({tag, ".ovf"}, {63'd0, ovf}, {63'd0, eo});
`else
    if (eo === 1'bx) $display("unexpected unknown overflow expectation");
`endif
  endtask

  logic [31:0] exp_s;
  logic        exp_c, exp_o;
  logic [33:0] m;
  logic [31:0] ra, rb;
  logic        rv, rc;

  initial begin
    vecs[0] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0};
    vecs[1] = '{32'h00000002, 32'h00000002, 1'b0, 32'h00000004, 1'b0, 1'b0};
    vecs[2] = '{32'h00000004, 32'h00000005, 1'b1, 32'h0000000A, 1'b0, 1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[4] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0};
    vecs[5] = '{32'h67584132, 32'h32415867, 1'b0, 32'h99999999, 1'b0, 1'b1};
    vecs[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0};
    vecs[7] = '{32'h99999999, 32'h99999999, 1'b1, 32'h33333333, 1'b1, 1'b1};
    vecs[8] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1};

    rst_n = 1'b1;
    drive(1'b0, 32'd0, 32'd0, 1'b0);

    // Asynchronous reset between edges clears outputs before any clock edge.
    #2 rst_n = 1'b0;
    #1 check_out("reset_async", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors back-to-back; each result appears exactly one edge later.
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      #1;
      if (i > 0)
        check_out($sformatf("vec%0d_pre_edge", i), vecs[i-1].exp_s, vecs[i-1].exp_cout,
                  1'b1, vecs[i-1].exp_ovf);
      @(posedge clk);
      #1 check_out($sformatf("vec%0d", i), vecs[i].exp_s, vecs[i].exp_cout, 1'b1,
                   vecs[i].exp_ovf);
      @(negedge clk);
    end

    // Drop in_valid: out_valid falls, data holds across idle cycles.
    drive(1'b0, 32'h12345678, 32'h11111111, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1 check_out($sformatf("hold%0d", i), 32'h80000000, 1'b0, 1'b0, 1'b1);
    end

    // Randomized traffic against the reference model.
    exp_s = 32'h80000000;
    exp_c = 1'b0;
    exp_o = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      rv = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0:       ra = 32'hFFFFFFFF;
        1:       ra = 32'h7FFFFFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 3))
        0:       rb = 32'h00000000;
        1:       rb = 32'h80000000;
        default: rb = $urandom;
      endcase
      rc = $urandom_range(0, 1) == 1;
      drive(rv, ra, rb, rc);
      if (rv) begin
        m     = model(ra, rb, rc);
        exp_s = m[31:0];
        exp_c = m[32];
        exp_o = m[33];
      end
      @(posedge clk);
      #1 check_out($sformatf("rand%0d", i), exp_s, exp_c, rv, exp_o);
    end

    // Reset mid-stream discards the in-flight operation.
    @(negedge clk);
    drive(1'b1, 32'h0000FFFF, 32'h00000001, 1'b0);
    @(posedge clk);
    #1 check_out("pre_reset", 32'h00010000, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_out("reset_mid", 32'd0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1 check_out("reset_held", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(posedge clk);
    #1 check_out("post_reset_idle", 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    @(posedge clk);
    #1 check_out("post_reset_load", 32'hFFFFFFFF, 1'b1, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
